// File: rtl/alu_mul_sequencer_if.sv
// Execute-stage side of the shared multiplier sequencer: decode request,
// multiplier operands/product, register-file write port and status update.
interface alu_mul_sequencer_if;
    logic        start;
    logic        mode;
    logic [2:0]  rd_addr;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        flush;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_grant;
    logic [7:0]  status_in;
    logic [7:0]  status_out;
    logic        status_we;
    logic        busy;
    logic        done;

    modport master (
        output start, mode, rd_addr, op_a, op_b, flush, mul_p, rf_grant, status_in,
        input  mul_a, mul_b, rf_we, rf_waddr, rf_wdata, status_out, status_we, busy, done
    );

    modport slave (
        input  start, mode, rd_addr, op_a, op_b, flush, mul_p, rf_grant, status_in,
        output mul_a, mul_b, rf_we, rf_waddr, rf_wdata, status_out, status_we, busy, done
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle MUL/MLS controller: feeds the shared multiplier, waits its latency,
// writes the product back through the arbitrated register-file port and updates Z/N.
module alu_mul_sequencer #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input logic              clk,
    input logic              rst_n,
    alu_mul_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CALC, WR_LO, WR_HI, DONE} state_t;

    localparam logic [2:0] LAST = 3'(MUL_LATENCY - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  rd_q;
    logic        mode_q;
    logic [31:0] prod;

    // mul_a/mul_b double as the operand latches; all outputs are registered decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            rd_q           <= '0;
            mode_q         <= 1'b0;
            prod           <= '0;
            bus.mul_a      <= '0;
            bus.mul_b      <= '0;
            bus.rf_we      <= 1'b0;
            bus.rf_waddr   <= '0;
            bus.rf_wdata   <= '0;
            bus.status_out <= '0;
            bus.status_we  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done       <= 1'b0;
            bus.status_we  <= 1'b0;
            bus.status_out <= '0;
            if (state == IDLE) begin
                if (bus.start) begin
                    state     <= CALC;
                    cnt       <= '0;
                    rd_q      <= bus.rd_addr;
                    mode_q    <= bus.mode;
                    bus.mul_a <= bus.op_a;
                    bus.mul_b <= bus.op_b;
                    bus.busy  <= 1'b1;
                end
            end else if (bus.flush || state == DONE) begin
                state        <= IDLE;
                bus.busy     <= 1'b0;
                bus.mul_a    <= '0;
                bus.mul_b    <= '0;
                bus.rf_we    <= 1'b0;
                bus.rf_waddr <= '0;
                bus.rf_wdata <= '0;
            end else begin
                case (state)
                    CALC: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == LAST) begin
                            state        <= WR_LO;
                            prod         <= bus.mul_p;
                            bus.rf_we    <= 1'b1;
                            bus.rf_waddr <= rd_q;
                            bus.rf_wdata <= bus.mul_p[15:0];
                        end
                    end
                    WR_LO: begin
                        if (bus.rf_grant) begin
                            if (!mode_q) begin
                                state        <= WR_HI;
                                bus.rf_waddr <= rd_q + 3'd1;
                                bus.rf_wdata <= prod[31:16];
                            end else begin
                                state          <= DONE;
                                bus.rf_we      <= 1'b0;
                                bus.rf_waddr   <= '0;
                                bus.rf_wdata   <= '0;
                                bus.done       <= 1'b1;
                                bus.status_we  <= 1'b1;
                                bus.status_out <= {prod == 32'd0, prod[31], bus.status_in[5:0]};
                            end
                        end
                    end
                    WR_HI: begin
                        if (bus.rf_grant) begin
                            state          <= DONE;
                            bus.rf_we      <= 1'b0;
                            bus.rf_waddr   <= '0;
                            bus.rf_wdata   <= '0;
                            bus.done       <= 1'b1;
                            bus.status_we  <= 1'b1;
                            bus.status_out <= {prod == 32'd0, prod[31], bus.status_in[5:0]};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
